axum_bus_arb: RTL and testbench
===============================

AXUM_BUS_ARB -- requirements
Module: axum_bus_arb

Interface
REQ-001 Parameter NrHosts, default 2: number of host ports, range 1..8.
REQ-002 Parameter NrDevices, default 4: number of device ports, range 1..16.
REQ-003 Parameter DataWidth, default 32: data width in bits.
REQ-004 Parameter AddressWidth, default 32: address width in bits.
REQ-005 Parameter TimeoutCycles, default 16: maximum wait for device rvalid, range 2..255.
REQ-006 clk_i  input  1  single clock; all logic on rising edge.
REQ-007 rst_i  input  1  reset; synchronous, active-high.
REQ-008 host_req_i / host_we_i  input  1 each [NrHosts]  request; write enable.
REQ-009 host_addr_i  input  AddressWidth [NrHosts]  byte address.
REQ-010 host_be_i  input  DataWidth/8 [NrHosts]  byte enables.
REQ-011 host_wdata_i  input  DataWidth [NrHosts]  write data.
REQ-012 host_gnt_o / host_rvalid_o / host_err_o  output  1 each [NrHosts]  grant; response valid; error.
REQ-013 host_rdata_o  output  DataWidth [NrHosts]  read data.
REQ-014 device_req_o / device_we_o  output  1 each [NrDevices]; device_addr_o AddressWidth, device_be_o DataWidth/8, device_wdata_o DataWidth, all [NrDevices].
REQ-015 device_rvalid_i / device_err_i  input  1 each [NrDevices]; device_rdata_i  input  DataWidth [NrDevices].
REQ-016 cfg_device_addr_base_i / cfg_device_addr_mask_i  input  AddressWidth [NrDevices]  static address map.

Function
REQ-017 Decode: device d SHALL match when (addr & mask[d]) == base[d]; the lowest matching index wins; no match is a decode error.
REQ-018 FSM states: IDLE, WAIT, ERR; exactly one transaction is in flight at a time.
REQ-019 IDLE: when any host_req_i is high, exactly one host is granted combinationally in the same cycle: host_gnt_o high, all other host_gnt_o low.
REQ-020 Arbitration is round-robin: the search starts at index (last granted + 1) mod NrHosts; the pointer after reset is NrHosts-1, so host 0 wins first.
REQ-021 Grant to a mapped address: device_req_o[d] is high for that cycle only, with addr/we/be/wdata copied from the winning host; FSM enters WAIT and latches the host and device indices.
REQ-022 Grant to an unmapped address: no device_req_o is asserted; FSM enters ERR.
REQ-023 ERR: for one cycle, host_rvalid_o=1, host_err_o=1, host_rdata_o=0 to the latched host; then FSM returns to IDLE.
REQ-024 WAIT: no grants are issued and all device_req_o stay 0; the timeout counter starts at 0 and increments each cycle.
REQ-025 Response routing: when device_rvalid_i of the latched device is high, forward rvalid, rdata and err combinationally to the latched host in that cycle; FSM returns to IDLE.
REQ-026 Timeout: if the counter reaches TimeoutCycles-1 without rvalid, the bus drives rvalid=1, err=1, rdata=0 to the latched host in that cycle; FSM returns to IDLE.
REQ-027 A device rvalid arriving after a timeout, or from a non-latched device, is ignored.
REQ-028 A new grant may occur in the cycle after rvalid is delivered; back-to-back throughput is at most one transaction per 2 cycles.
REQ-029 Outputs not selected are 0, including host_rdata_o and device_addr_o, device_be_o and device_wdata_o of idle ports.
REQ-030 A host holds req and payload stable until it is granted; the bus does not register request payload.

Reset
REQ-031 While rst_i is high: FSM=IDLE, timeout counter=0, RR pointer=NrHosts-1, and all gnt, rvalid, err and device_req outputs are 0.
REQ-032 Reset asserted in WAIT or ERR abandons the transaction; the host receives no rvalid.

Verification
REQ-033 Bench covers: host0 reads 0x100004 (RAM base 0x100000, mask ~0x1FFF); RAM rvalid comes 1 cycle later with 0xDEADBEEF -> host0 gnt in cycle 0, host0 rvalid=1 and rdata=0xDEADBEEF in cycle 1, err=0.
REQ-034 Bench covers: host0 and host1 request continuously -> grant order 0,1,0,1 with each grant 2 cycles apart.
REQ-035 Bench covers: write to 0x40000 (unmapped) -> gnt, no device_req, next cycle rvalid=1, err=1, rdata=0.
REQ-036 Bench covers: device never asserts rvalid, TimeoutCycles=16 -> rvalid=1, err=1 exactly 16 cycles after gnt; a late device rvalid is ignored.
REQ-037 Bench covers: rst_i asserted in WAIT -> next cycle all outputs are 0; the first grant after reset goes to host 0.

Source files
------------

// File: rtl/axum_bus_arb.sv
// axum_bus_arb: round-robin multi-host to multi-device bus arbiter with address decode and response timeout
module axum_bus_arb #(
  parameter int NrHosts       = 2,
  parameter int NrDevices     = 4,
  parameter int DataWidth     = 32,
  parameter int AddressWidth  = 32,
  parameter int TimeoutCycles = 16
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [NrHosts-1:0]                       host_req_i,
  input  logic [NrHosts-1:0]                       host_we_i,
  input  logic [NrHosts-1:0][AddressWidth-1:0]     host_addr_i,
  input  logic [NrHosts-1:0][DataWidth/8-1:0]      host_be_i,
  input  logic [NrHosts-1:0][DataWidth-1:0]        host_wdata_i,
  output logic [NrHosts-1:0]                       host_gnt_o,
  output logic [NrHosts-1:0]                       host_rvalid_o,
  output logic [NrHosts-1:0]                       host_err_o,
  output logic [NrHosts-1:0][DataWidth-1:0]        host_rdata_o,
  output logic [NrDevices-1:0]                     device_req_o,
  output logic [NrDevices-1:0]                     device_we_o,
  output logic [NrDevices-1:0][AddressWidth-1:0]   device_addr_o,
  output logic [NrDevices-1:0][DataWidth/8-1:0]    device_be_o,
  output logic [NrDevices-1:0][DataWidth-1:0]      device_wdata_o,
  input  logic [NrDevices-1:0]                     device_rvalid_i,
  input  logic [NrDevices-1:0]                     device_err_i,
  input  logic [NrDevices-1:0][DataWidth-1:0]      device_rdata_i,
  input  logic [NrDevices-1:0][AddressWidth-1:0]   cfg_device_addr_base_i,
  input  logic [NrDevices-1:0][AddressWidth-1:0]   cfg_device_addr_mask_i
);
  localparam int HW = NrHosts > 1 ? $clog2(NrHosts) : 1;
  localparam int DW = NrDevices > 1 ? $clog2(NrDevices) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, ERR} state_e;
  state_e state_q, state_d;
  logic [HW-1:0] last_q, last_d, host_q, host_d, win;
  logic [DW-1:0] dev_q, dev_d, dev;
  logic [7:0] cnt_q, cnt_d;
  logic any_req, hit;
  // Round-robin search: lower offsets from last+1 overwrite higher ones.
  always_comb begin
    win = '0;
    any_req = |host_req_i;
    for (int i = NrHosts - 1; i >= 0; i--)
      if (host_req_i[(int'(last_q) + 1 + i) % NrHosts]) win = HW'((int'(last_q) + 1 + i) % NrHosts);
  end
  always_comb begin
    dev = '0;
    hit = 1'b0;
    for (int d = NrDevices - 1; d >= 0; d--)
      if ((host_addr_i[win] & cfg_device_addr_mask_i[d]) == cfg_device_addr_base_i[d]) begin
        dev = DW'(d);
        hit = 1'b1;
      end
  end
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    host_d = host_q;
    dev_d = dev_q;
    cnt_d = cnt_q;
    host_gnt_o = '0;
    host_rvalid_o = '0;
    host_err_o = '0;
    host_rdata_o = '0;
    device_req_o = '0;
    device_we_o = '0;
    device_addr_o = '0;
    device_be_o = '0;
    device_wdata_o = '0;
    case (state_q)
      IDLE: if (any_req) begin
        host_gnt_o[win] = 1'b1;
        last_d = win;
        host_d = win;
        dev_d = dev;
        cnt_d = '0;
        state_d = hit ? WAIT : ERR;
        if (hit) begin
          device_req_o[dev] = 1'b1;
          device_we_o[dev] = host_we_i[win];
          device_addr_o[dev] = host_addr_i[win];
          device_be_o[dev] = host_be_i[win];
          device_wdata_o[dev] = host_wdata_i[win];
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (device_rvalid_i[dev_q]) begin
          host_rvalid_o[host_q] = 1'b1;
          host_err_o[host_q] = device_err_i[dev_q];
          host_rdata_o[host_q] = device_rdata_i[dev_q];
          state_d = IDLE;
        end else if (cnt_q == 8'(TimeoutCycles - 1)) begin
          host_rvalid_o[host_q] = 1'b1;
          host_err_o[host_q] = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        host_rvalid_o[host_q] = 1'b1;
        host_err_o[host_q] = 1'b1;
        state_d = IDLE;
      end
    endcase
    // Outputs are quiet for the whole reset cycle, even in IDLE with requests pending.
    if (rst_i) begin
      host_gnt_o = '0;
      host_rvalid_o = '0;
      host_err_o = '0;
      host_rdata_o = '0;
      device_req_o = '0;
      device_we_o = '0;
      device_addr_o = '0;
      device_be_o = '0;
      device_wdata_o = '0;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q <= HW'(NrHosts - 1);
      host_q <= '0;
      dev_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      host_q <= host_d;
      dev_q <= dev_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_axum_bus_arb.sv
// tb_axum_bus_arb: directed self-checking bench for axum_bus_arb
module tb_axum_bus_arb;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] host_req, host_we, host_gnt, host_rvalid, host_err;
  logic [1:0][31:0] host_addr, host_wdata, host_rdata;
  logic [1:0][3:0] host_be;
  logic [3:0] device_req, device_we, device_rvalid, device_err;
  logic [3:0][31:0] device_addr, device_wdata, device_rdata, cfg_base, cfg_mask;
  logic [3:0][3:0] device_be;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axum_bus_arb dut (
    .clk_i(clk), .rst_i(rst),
    .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr),
    .host_be_i(host_be), .host_wdata_i(host_wdata),
    .host_gnt_o(host_gnt), .host_rvalid_o(host_rvalid), .host_err_o(host_err),
    .host_rdata_o(host_rdata),
    .device_req_o(device_req), .device_we_o(device_we), .device_addr_o(device_addr),
    .device_be_o(device_be), .device_wdata_o(device_wdata),
    .device_rvalid_i(device_rvalid), .device_err_i(device_err), .device_rdata_i(device_rdata),
    .cfg_device_addr_base_i(cfg_base), .cfg_device_addr_mask_i(cfg_mask)
  );

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic test_reset;
    tick();
    host_req = 2'b11;
    host_addr[0] = 32'h0010_0000;
    host_addr[1] = 32'h0010_0000;
    #1;
    checks++;
    if (host_gnt !== 2'b00 || device_req !== 4'b0000) begin
      errors++;
      $display("FAIL reset_gnt: gnt=%b dreq=%b, want 00/0000", host_gnt, device_req);
    end
    checks++;
    if (host_rvalid !== 2'b00 || host_err !== 2'b00 || host_rdata !== '0) begin
      errors++;
      $display("FAIL reset_resp: rvalid=%b err=%b rdata=%h, want zeros", host_rvalid, host_err, host_rdata);
    end
    tick();
    host_req = 2'b00;
    rst = 1'b0;
  endtask

  task automatic test_read;
    tick();
    host_req = 2'b01;
    host_we = 2'b00;
    host_addr[0] = 32'h0010_0004;
    host_be[0] = 4'hF;
    #1;
    checks++;
    if (host_gnt !== 2'b01 || device_req !== 4'b0001) begin
      errors++;
      $display("FAIL read_gnt: gnt=%b dreq=%b, want 01/0001", host_gnt, device_req);
    end
    checks++;
    if (device_addr[0] !== 32'h0010_0004 || device_addr[1] !== 32'h0 || device_be[0] !== 4'hF) begin
      errors++;
      $display("FAIL read_payload: addr0=%h addr1=%h be0=%h", device_addr[0], device_addr[1], device_be[0]);
    end
    tick();
    host_req = 2'b00;
    device_rvalid = 4'b0001;
    device_rdata[0] = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (host_rvalid !== 2'b01 || host_err !== 2'b00 || host_rdata[0] !== 32'hDEAD_BEEF || host_rdata[1] !== 32'h0) begin
      errors++;
      $display("FAIL read_resp: rvalid=%b err=%b rdata0=%h rdata1=%h, want 01/00/deadbeef/0",
               host_rvalid, host_err, host_rdata[0], host_rdata[1]);
    end
    tick();
    device_rvalid = 4'b0000;
  endtask

  task automatic test_unmapped;
    host_req = 2'b10;
    host_we = 2'b10;
    host_addr[1] = 32'h0004_0000;
    host_wdata[1] = 32'h1234_5678;
    #1;
    checks++;
    if (host_gnt !== 2'b10 || device_req !== 4'b0000) begin
      errors++;
      $display("FAIL unmapped_gnt: gnt=%b dreq=%b, want 10/0000", host_gnt, device_req);
    end
    tick();
    host_req = 2'b00;
    #1;
    checks++;
    if (host_rvalid !== 2'b10 || host_err !== 2'b10 || host_rdata !== '0) begin
      errors++;
      $display("FAIL unmapped_resp: rvalid=%b err=%b rdata=%h, want 10/10/0", host_rvalid, host_err, host_rdata);
    end
    tick();
    host_we = 2'b00;
  endtask

  task automatic test_back_to_back;
    logic [1:0] order [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    host_req = 2'b11;
    host_addr[0] = 32'h0010_0008;
    host_addr[1] = 32'h0010_0008;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (host_gnt !== order[k] || device_req !== 4'b0001) begin
        errors++;
        $display("FAIL b2b_gnt%0d: gnt=%b dreq=%b, want %b/0001", k, host_gnt, device_req, order[k]);
      end
      tick();
      device_rvalid = 4'b0001;
      device_rdata[0] = 32'h1000 + k;
      #1;
      checks++;
      if (host_gnt !== 2'b00 || host_rvalid !== order[k] || host_rdata !== ((order[k] == 2'b01) ? {32'h0, 32'h1000 + k} : {32'h1000 + k, 32'h0})) begin
        errors++;
        $display("FAIL b2b_resp%0d: gnt=%b rvalid=%b rdata=%h", k, host_gnt, host_rvalid, host_rdata);
      end
      tick();
      device_rvalid = 4'b0000;
    end
    host_req = 2'b00;
  endtask

  task automatic test_timeout;
    host_req = 2'b01;
    host_addr[0] = 32'h8000_0010;
    #1;
    checks++;
    if (host_gnt !== 2'b01 || device_req !== 4'b0100) begin
      errors++;
      $display("FAIL timeout_gnt: gnt=%b dreq=%b, want 01/0100", host_gnt, device_req);
    end
    for (int k = 1; k <= 15; k++) begin
      tick();
      host_req = 2'b00;
      device_rvalid = (k == 5) ? 4'b0001 : 4'b0000;
      device_rdata[0] = 32'hBAD0_0000;
      #1;
      checks++;
      if (host_rvalid !== 2'b00) begin
        errors++;
        $display("FAIL timeout_wait%0d: rvalid=%b, want 00", k, host_rvalid);
      end
    end
    tick();
    #1;
    checks++;
    if (host_rvalid !== 2'b01 || host_err !== 2'b01 || host_rdata !== '0) begin
      errors++;
      $display("FAIL timeout_fire: rvalid=%b err=%b rdata=%h, want 01/01/0", host_rvalid, host_err, host_rdata);
    end
    tick();
    device_rvalid = 4'b0100;
    device_rdata[2] = 32'h5555_AAAA;
    #1;
    checks++;
    if (host_rvalid !== 2'b00 || host_gnt !== 2'b00 || host_rdata !== '0) begin
      errors++;
      $display("FAIL timeout_late: rvalid=%b gnt=%b rdata=%h, want 00/00/0", host_rvalid, host_gnt, host_rdata);
    end
    tick();
    device_rvalid = 4'b0000;
  endtask

  task automatic test_reset_in_wait;
    host_req = 2'b10;
    host_addr[1] = 32'h0010_0000;
    #1;
    checks++;
    if (host_gnt !== 2'b10 || device_req !== 4'b0001) begin
      errors++;
      $display("FAIL rstwait_gnt: gnt=%b dreq=%b, want 10/0001", host_gnt, device_req);
    end
    tick();
    host_req = 2'b00;
    rst = 1'b1;
    device_rvalid = 4'b0001;
    device_rdata[0] = 32'hCAFE_F00D;
    #1;
    checks++;
    if (host_gnt !== 2'b00 || host_rvalid !== 2'b00 || host_err !== 2'b00 || host_rdata !== '0 ||
        device_req !== 4'b0000 || device_addr !== '0) begin
      errors++;
      $display("FAIL rstwait_quiet: gnt=%b rvalid=%b err=%b dreq=%b, want all 0", host_gnt, host_rvalid, host_err, device_req);
    end
    tick();
    rst = 1'b0;
    device_rvalid = 4'b0000;
    host_req = 2'b11;
    host_addr[0] = 32'h0010_0000;
    #1;
    checks++;
    if (host_gnt !== 2'b01 || host_rvalid !== 2'b00) begin
      errors++;
      $display("FAIL rstwait_first: gnt=%b rvalid=%b, want 01/00", host_gnt, host_rvalid);
    end
    tick();
    host_req = 2'b00;
    device_rvalid = 4'b0001;
    device_rdata[0] = 32'h0000_0042;
    #1;
    checks++;
    if (host_rvalid !== 2'b01 || host_rdata[0] !== 32'h42) begin
      errors++;
      $display("FAIL rstwait_resp: rvalid=%b rdata0=%h, want 01/42", host_rvalid, host_rdata[0]);
    end
    tick();
    device_rvalid = 4'b0000;
  endtask

  initial begin
    rst = 1'b1;
    host_req = '0;
    host_we = '0;
    host_addr = '0;
    host_be = '0;
    host_wdata = '0;
    device_rvalid = '0;
    device_err = '0;
    device_rdata = '0;
    cfg_base[0] = 32'h0010_0000; cfg_mask[0] = ~32'h1FFF;
    cfg_base[1] = 32'h0010_0000; cfg_mask[1] = 32'hFFF0_0000;
    cfg_base[2] = 32'h8000_0000; cfg_mask[2] = 32'hF000_0000;
    cfg_base[3] = 32'hFFFF_FFFF; cfg_mask[3] = 32'h0000_0000;
    test_reset();
    test_read();
    test_unmapped();
    test_back_to_back();
    test_timeout();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
